// File: rtl/fifo92gmii_pkg.sv
// Shared definitions for the FIFO-to-GMII transmit path: state encodings,
// GMII framing bytes and the ctl-bit meaning shared with the receive side.
package fifo92gmii_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PREAMBLE = 3'd1,
    ST_SFD      = 3'd2,
    ST_DATA     = 3'd3,
    ST_DROP     = 3'd4,
    ST_IFG      = 3'd5
  } state_t;

  localparam logic [7:0] GMII_PREAMBLE = 8'h55;
  localparam logic [7:0] GMII_SFD      = 8'hD5;

  localparam logic CTL_DATA = 1'b1;
  localparam logic CTL_GAP  = 1'b0;

endpackage

// File: rtl/fifo92gmii.sv
// Drains {ctl, byte} words from a first-word-fall-through FIFO onto a GMII
// transmitter, adding preamble/SFD, inter-frame gap and underrun signalling.
module fifo92gmii
  import fifo92gmii_pkg::*;
#(
  parameter logic [3:0] PreambleLen = 4'h7,
  parameter logic [4:0] Ifg         = 5'd12
) (
  input  logic       gmii_tx_clk,
  input  logic       sys_rst,
  input  logic [8:0] dout,
  input  logic       empty,
  output logic       rd_en,
  output logic       rd_clk,
  output logic       gmii_tx_en,
  output logic [7:0] gmii_txd,
  output logic       gmii_tx_er
);

  state_t     state, state_nx;
  logic [3:0] pre_cnt, pre_cnt_nx;
  logic [4:0] ifg_cnt, ifg_cnt_nx;
  logic       tx_en_nx, tx_er_nx;
  logic [7:0] txd_nx;
  logic       head_data, head_gap, pop;

  assign rd_clk = gmii_tx_clk;

  // FIFO handshake: dout is valid whenever empty=0; rd_en is only raised with
  // empty=0 and consumes the head word at the rising edge it is high.
  assign head_data = !empty && (dout[8] == CTL_DATA);
  assign head_gap  = !empty && (dout[8] == CTL_GAP);
  assign rd_en     = pop && !sys_rst;

  always_comb begin
    state_nx   = state;
    pre_cnt_nx = pre_cnt;
    ifg_cnt_nx = ifg_cnt;
    tx_en_nx   = 1'b0;
    tx_er_nx   = 1'b0;
    txd_nx     = 8'h00;
    pop        = 1'b0;
    unique case (state)
      ST_IDLE: begin
        pop = head_gap;
        if (head_data) begin
          state_nx   = ST_PREAMBLE;
          pre_cnt_nx = PreambleLen - 4'd1;
          tx_en_nx   = 1'b1;
          txd_nx     = GMII_PREAMBLE;
        end
      end
      ST_PREAMBLE: begin
        tx_en_nx = 1'b1;
        if (pre_cnt == 4'd0) begin
          state_nx = ST_SFD;
          txd_nx   = GMII_SFD;
        end else begin
          pre_cnt_nx = pre_cnt - 4'd1;
          txd_nx     = GMII_PREAMBLE;
        end
      end
      // Registered outputs lag one cycle, so the byte popped here is on the wire next.
      ST_SFD, ST_DATA: begin
        pop = !empty;
        if (head_data) begin
          state_nx = ST_DATA;
          tx_en_nx = 1'b1;
          txd_nx   = dout[7:0];
        end else if (head_gap) begin
          state_nx   = ST_IFG;
          ifg_cnt_nx = Ifg - 5'd1;
        end else begin
          state_nx = ST_DROP;
          tx_en_nx = 1'b1;
          tx_er_nx = 1'b1;
        end
      end
      ST_DROP: begin
        pop = !empty;
        if (head_gap) begin
          state_nx   = ST_IFG;
          ifg_cnt_nx = Ifg - 5'd1;
        end
      end
      ST_IFG: begin
        pop = head_gap;
        if (ifg_cnt == 5'd0) state_nx = ST_IDLE;
        else                 ifg_cnt_nx = ifg_cnt - 5'd1;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge gmii_tx_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state      <= ST_IDLE;
      pre_cnt    <= 4'd0;
      ifg_cnt    <= 5'd0;
      gmii_tx_en <= 1'b0;
      gmii_tx_er <= 1'b0;
      gmii_txd   <= 8'h00;
    end else begin
      state      <= state_nx;
      pre_cnt    <= pre_cnt_nx;
      ifg_cnt    <= ifg_cnt_nx;
      gmii_tx_en <= tx_en_nx;
      gmii_tx_er <= tx_er_nx;
      gmii_txd   <= txd_nx;
    end
  end

endmodule

// File: tb/tb_fifo92gmii.sv
// Bench for fifo92gmii: default instance plus a PreambleLen=1/Ifg=1 instance,
// each fed by a queue-based FWFT FIFO model and checked by a GMII monitor.
module tb_fifo92gmii;

  logic       clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic [8:0] dout0 = 9'h0, dout1 = 9'h0;
  logic       empty0 = 1'b1, empty1 = 1'b1;
  logic       rd_en0, rd_en1, rd_clk0, rd_clk1;
  logic       en0, en1, er0, er1;
  logic [7:0] txd0, txd1;

  logic [8:0] fq0[$], fq1[$];
  logic [8:0] exp_q0[$], exp_q1[$];
  int errors = 0, checks = 0;
  int pops0 = 0, pops1 = 0;
  int low_run0 = 0, low_run1 = 0, last_gap0 = 0, last_gap1 = 0;
  bit seen0 = 1'b0, seen1 = 1'b0;
  logic pop_s0 = 1'b0, pop_s1 = 1'b0;

  // clock / reset
  always #5 clk = ~clk;

  fifo92gmii dut0 (
    .gmii_tx_clk(clk), .sys_rst(sys_rst), .dout(dout0), .empty(empty0),
    .rd_en(rd_en0), .rd_clk(rd_clk0), .gmii_tx_en(en0), .gmii_txd(txd0),
    .gmii_tx_er(er0)
  );

  fifo92gmii #(.PreambleLen(4'd1), .Ifg(5'd1)) dut1 (
    .gmii_tx_clk(clk), .sys_rst(sys_rst), .dout(dout1), .empty(empty1),
    .rd_en(rd_en1), .rd_clk(rd_clk1), .gmii_tx_en(en1), .gmii_txd(txd1),
    .gmii_tx_er(er1)
  );

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
    end
  endtask

  // FWFT FIFO models: pop requests sampled mid-cycle, head refreshed after the edge
  always @(negedge clk) begin
    pop_s0 = rd_en0;
    pop_s1 = rd_en1;
    if (rd_en0) check("rd_en0_while_empty", int'(empty0), 0);
    if (rd_en1) check("rd_en1_while_empty", int'(empty1), 0);
  end

  always @(posedge clk) begin
    if (pop_s0 && fq0.size() > 0) begin void'(fq0.pop_front()); pops0++; end
    if (pop_s1 && fq1.size() > 0) begin void'(fq1.pop_front()); pops1++; end
    #1;
    empty0 = (fq0.size() == 0);
    dout0  = empty0 ? 9'h000 : fq0[0];
    empty1 = (fq1.size() == 0);
    dout1  = empty1 ? 9'h000 : fq1[0];
  end

  // scoreboard monitors: every tx_en cycle must match the next expected {er, txd}
  always @(negedge clk) begin
    logic [8:0] e;
    if (sys_rst) begin
      seen0 = 1'b0; seen1 = 1'b0; low_run0 = 0; low_run1 = 0;
    end else begin
      if (en0) begin
        if (seen0 && low_run0 > 0) begin
          last_gap0 = low_run0;
          check("gap0_min", int'(low_run0 >= 13), 1);
        end
        low_run0 = 0;
        seen0 = 1'b1;
        if (exp_q0.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected0: got er=%0b txd=%0h required no transmit", er0, txd0);
        end else begin
          e = exp_q0.pop_front();
          check("txd0", int'({er0, txd0}), int'(e));
        end
      end else begin
        low_run0++;
        if (er0) check("er0_without_en", int'(er0), 0);
      end
      if (en1) begin
        if (seen1 && low_run1 > 0) begin
          last_gap1 = low_run1;
          check("gap1_min", int'(low_run1 >= 2), 1);
        end
        low_run1 = 0;
        seen1 = 1'b1;
        if (exp_q1.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected1: got er=%0b txd=%0h required no transmit", er1, txd1);
        end else begin
          e = exp_q1.pop_front();
          check("txd1", int'({er1, txd1}), int'(e));
        end
      end else begin
        low_run1++;
        if (er1) check("er1_without_en", int'(er1), 0);
      end
    end
  end

  // driver tasks
  task automatic push_word(input int which, input logic [8:0] w);
    if (which == 0) fq0.push_back(w); else fq1.push_back(w);
  endtask

  task automatic expect_out(input int which, input logic [8:0] v);
    if (which == 0) exp_q0.push_back(v); else exp_q1.push_back(v);
  endtask

  task automatic expect_preamble(input int which);
    int plen;
    plen = (which == 0) ? 7 : 1;
    for (int i = 0; i < plen; i++) expect_out(which, 9'h055);
    expect_out(which, 9'h0D5);
  endtask

  task automatic send_frame(input int which, input int n, input logic [7:0] first,
                            input int seps);
    logic [7:0] b;
    expect_preamble(which);
    for (int i = 0; i < n; i++) begin
      b = first + 8'(i);
      push_word(which, {1'b1, b});
      expect_out(which, {1'b0, b});
    end
    for (int i = 0; i < seps; i++) push_word(which, 9'h000);
  endtask

  task automatic wait_done(input int which, input int budget);
    int n;
    n = 0;
    while (((which == 0) ? (exp_q0.size() + fq0.size()) : (exp_q1.size() + fq1.size())) != 0
           && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (n >= budget) begin
      checks++; errors++;
      $display("FAIL timeout%0d: got %0d cycles required < %0d", which, n, budget);
    end
    repeat (3) @(posedge clk);
    #2;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int p, n;
    // Test 1: short frame preloaded during reset, with a leading separator
    push_word(0, 9'h000);
    send_frame(0, 3, 8'h01, 2);
    repeat (3) @(posedge clk);
    #2;
    check("rst_tx_en", int'(en0), 0);
    check("rst_txd", int'(txd0), 0);
    check("rst_tx_er", int'(er0), 0);
    check("rst_rd_en", int'(rd_en0), 0);
    sys_rst = 1'b0;
    @(posedge clk); #2;
    check("t1_no_preamble_yet", int'(en0), 0);
    @(posedge clk); #2;
    check("t1_preamble_start", int'(en0), 1);
    wait_done(0, 200);
    check("t1_pops", pops0, 6);

    // Test 2: two 60-byte frames back to back
    send_frame(0, 60, 8'h10, 1);
    send_frame(0, 60, 8'h80, 1);
    wait_done(0, 600);
    check("t2_gap", last_gap0, 13);

    // Test 3: underrun after byte 3, then refill and a following frame
    p = pops0;
    send_frame(0, 3, 8'h01, 0);
    expect_out(0, 9'h100);
    wait_done(0, 100);
    repeat (5) @(posedge clk);
    #2;
    for (int i = 4; i <= 10; i++) push_word(0, {1'b1, 8'(i)});
    push_word(0, 9'h000);
    send_frame(0, 2, 8'hC0, 1);
    wait_done(0, 200);
    check("t3_pops", pops0 - p, 14);

    // Test 4: separators only
    p = pops0;
    for (int i = 0; i < 4; i++) push_word(0, 9'h000);
    repeat (5) @(posedge clk);
    #2;
    check("t4_pops", pops0 - p, 4);
    repeat (20) @(posedge clk);
    #2;

    // Test 5: reset during the 5th preamble byte
    p = pops0;
    send_frame(0, 4, 8'h21, 1);
    n = 0;
    while (!en0 && n < 100) begin @(posedge clk); #2; n++; end
    check("t5_start", int'(en0), 1);
    repeat (4) @(posedge clk);
    #2;
    check("t5_pre5_txd", int'(txd0), 8'h55);
    sys_rst = 1'b1;
    #1;
    check("t5_rst_tx_en", int'(en0), 0);
    check("t5_rst_txd", int'(txd0), 0);
    check("t5_rst_tx_er", int'(er0), 0);
    check("t5_rst_rd_en", int'(rd_en0), 0);
    exp_q0.delete();
    expect_preamble(0);
    for (int i = 0; i < 4; i++) expect_out(0, {1'b0, 8'h21 + 8'(i)});
    repeat (2) @(posedge clk);
    #2;
    sys_rst = 1'b0;
    wait_done(0, 200);
    check("t5_pops", pops0 - p, 5);

    // Test 6: PreambleLen=1, Ifg=1 instance
    send_frame(1, 2, 8'hAA, 1);
    send_frame(1, 1, 8'hCC, 1);
    wait_done(1, 100);
    check("t6_gap", last_gap1, 2);
    check("t6_pops", pops1, 5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
